twiddle_feed: RTL and testbench
===============================

# twiddle_feed

Streaming stage directly upstream of the 64-bit complex multiplier in the radix-4 16-point FFT. Accepts the 16 first-stage butterfly outputs of a frame in natural order, pairs each sample with its twiddle factor W16^((i>>2)·(i&3)), and presents data on X/Y and twiddle on L/M through one registered valid/ready slice. It also tracks frame position and flags input frames that are misaligned.

## Interface
- DW, 64, width of each real/imag component; the multiplier is fixed at 64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_re  in  DW  sample real part, signed.
- in_im  in  DW  sample imaginary part, signed.
- in_last  in  1  sample is index 15 of its frame.
- out_valid  out  1  output slice holds a sample/twiddle pair.
- out_ready  in  1  downstream accepts the pair.
- out_x  out  DW  data real part, driven to multiplier X.
- out_y  out  DW  data imaginary part, driven to multiplier Y.
- out_l  out  DW  twiddle real part cos(2πe/16), driven to L.
- out_m  out  DW  twiddle imaginary part −sin(2πe/16), driven to M.
- out_idx  out  4  sample index i within the frame.
- out_last  out  1  out_idx == 15.
- err  out  1  sticky frame-alignment error.

## Operation
- 4-bit index counter `idx` counts accepted samples (in_valid && in_ready). It increments and wraps 15→0.
- Twiddle exponent is e = (idx[3:2] · idx[1:0]) mod 16. Reachable values are {0,1,2,3,4,6,9}.
- Twiddle encoding is Q1.63. Each coefficient is round-half-away-from-zero(v·2^63), saturated to ±(2^63−1).
  - Exact encodings: 1.0 = 0x7FFF_FFFF_FFFF_FFFF; 0.0 = 0; −1.0 = 0x8000_0000_0000_0001.
  - Coefficients come from a 7-entry constant ROM indexed by e. No multiplier is used.
  - Table: e0 (1,0); e1 (c1,−s1); e2 (c2,−c2); e3 (s1,−c1); e4 (0,−1); e6 (−c2,−c2); e9 (−c1,s1). Here c1 = 0.9238795325, s1 = 0.3826834324, c2 = 0.7071067812.
- Output slice is a single register stage.
  - in_ready = !out_valid || out_ready.
  - On acceptance, the slice loads in_re→out_x, in_im→out_y, ROM(e)→out_l/out_m, idx→out_idx, (idx==15)→out_last. It then sets out_valid.
  - If out_valid && out_ready and there is no acceptance that cycle, out_valid clears.
  - Simultaneous accept and drain reloads the slice; out_valid stays 1.
  - While out_valid && !out_ready, all out_* hold stable.
- Alignment check, evaluated on an accepted sample:
  - If in_last != (idx==15), err sets and stays set until reset.
  - If in_last=1 at idx≠15, the counter resynchronizes: the next accepted sample gets idx 0.
  - The current sample is still emitted with its counted idx and out_last = (idx==15).
  - A missing in_last at idx 15 sets err. The counter still wraps to 0.
- Data values pass unmodified. Scaling happens downstream: the multiplier keeps product bits [127:64], so its output is data·W/2 (≈).

## Timing
- Reset (async assert, synchronous-safe deassert): out_valid=0, idx=0, err=0, out_x/out_y/out_l/out_m=0, out_idx=0, out_last=0. in_ready=1 from the first cycle after reset.
- Latency: a sample accepted at edge n appears on out_* with out_valid=1 after edge n.
- Throughput: 1 sample/cycle while out_ready=1. No bubbles.
- Backpressure: in_ready falls combinationally when out_valid && !out_ready. Inputs presented then are not accepted and the counter does not advance.
- Reset asserted mid-frame discards the slice contents and the count. The next accepted sample is idx 0.
- err is registered and asserts the cycle after the offending acceptance.

## Test plan
- Reset, then stream 16 samples with in_re=i, in_im=−i, in_last on i=15, out_ready=1 → out_idx 0..15 in order, out_last only at 15, err=0. For i=0..3 and i=4,8,12: out_l=0x7FFF_FFFF_FFFF_FFFF, out_m=0. For i=5: e=1. For i=15: e=9, out_l=−c1 code, out_m=+s1 code.
- Sample i=6 (e=2) and i=10 (e=4) → out_l/out_m = (c2 code, −c2 code) and (0, 0x8000_0000_0000_0001) respectively.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_* stable, idx frozen. Then release → no sample lost or duplicated; frame order intact.
- Misalignment: in_last at i=9 → err=1 next cycle. The next accepted sample has out_idx=0. err remains 1 across later good frames.
- Missing last: no in_last on i=15 → err=1. The next sample has out_idx=0.
- Async reset during sample 7 while out_valid=1 → out_valid=0 immediately, err=0. After release, the first sample has out_idx=0 with twiddle (1,0).

Source files
------------

// File: rtl/twiddle_feed.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | twiddle_feed: pairs radix-4 16-pt FFT samples with W16 twiddles and    |
// | feeds the complex multiplier through one valid/ready register slice.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module twiddle_feed #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_x,
  output logic [DW-1:0] out_y,
  output logic [DW-1:0] out_l,
  output logic [DW-1:0] out_m,
  output logic [3:0]    out_idx,
  output logic          out_last,
  output logic          err
);

  // Q1.63 codes, round-half-away-from-zero of v*2^63
  localparam logic [DW-1:0] C_ONE     = DW'(64'h7FFF_FFFF_FFFF_FFFF);
  localparam logic [DW-1:0] C_NEG_ONE = DW'(64'h8000_0000_0000_0001);
  localparam logic [DW-1:0] C_C1      = DW'(64'd8521284645587064995);
  localparam logic [DW-1:0] C_S1      = DW'(64'd3529631669043774883);
  localparam logic [DW-1:0] C_C2      = DW'(64'd6521908912666391106);
  localparam logic [DW-1:0] C_NC1     = -C_C1;
  localparam logic [DW-1:0] C_NS1     = -C_S1;
  localparam logic [DW-1:0] C_NC2     = -C_C2;

  logic [3:0]    r_cnt;
  logic          r_err;
  logic          r_valid;
  logic [DW-1:0] r_x;
  logic [DW-1:0] r_y;
  logic [DW-1:0] r_l;
  logic [DW-1:0] r_m;
  logic [3:0]    r_idx;
  logic          r_last;

  logic          w_accept;
  logic          w_cnt_last;
  logic [3:0]    w_exp;
  logic [DW-1:0] w_rom_l;
  logic [DW-1:0] w_rom_m;

  assign in_ready   = !r_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_cnt_last = (r_cnt == 4'd15);
  // 2x2-bit product never exceeds 9, so it fits without wrap
  assign w_exp      = {2'b00, r_cnt[3:2]} * {2'b00, r_cnt[1:0]};

  always_comb begin
    w_rom_l = '0;
    w_rom_m = '0;
    case (w_exp)
      4'd0: begin w_rom_l = C_ONE; w_rom_m = '0;        end
      4'd1: begin w_rom_l = C_C1;  w_rom_m = C_NS1;     end
      4'd2: begin w_rom_l = C_C2;  w_rom_m = C_NC2;     end
      4'd3: begin w_rom_l = C_S1;  w_rom_m = C_NC1;     end
      4'd4: begin w_rom_l = '0;    w_rom_m = C_NEG_ONE; end
      4'd6: begin w_rom_l = C_NC2; w_rom_m = C_NC2;     end
      4'd9: begin w_rom_l = C_NC1; w_rom_m = C_S1;      end
      default: begin w_rom_l = '0; w_rom_m = '0;        end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_l     <= '0;
      r_m     <= '0;
      r_idx   <= 4'd0;
      r_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_x     <= in_re;
        r_y     <= in_im;
        r_l     <= w_rom_l;
        r_m     <= w_rom_m;
        r_idx   <= r_cnt;
        r_last  <= w_cnt_last;
        // an early in_last resynchronises the frame to start over at 0
        r_cnt   <= (in_last || w_cnt_last) ? 4'd0 : r_cnt + 4'd1;
        if (in_last != w_cnt_last) begin
          r_err <= 1'b1;
        end
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_x     = r_x;
  assign out_y     = r_y;
  assign out_l     = r_l;
  assign out_m     = r_m;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_feed.sv
`default_nettype none
// Bench for twiddle_feed: directed phases with random data, scored against
// a queue-based frame model whose twiddles come from cosine symmetry.
module tb_twiddle_feed;

  localparam logic [63:0] C_ONE = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] C_C1  = 64'd8521284645587064995;
  localparam logic [63:0] C_S1  = 64'd3529631669043774883;
  localparam logic [63:0] C_C2  = 64'd6521908912666391106;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_re;
  logic [63:0] in_im;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_x;
  logic [63:0] out_y;
  logic [63:0] out_l;
  logic [63:0] out_m;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        err;

  twiddle_feed #(.DW(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_l    (out_l),
    .out_m    (out_m),
    .out_idx  (out_idx),
    .out_last (out_last),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] l;
    logic [63:0] m;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   pos;
  bit   m_err;
  int   checks;
  int   failures;

  function automatic logic [63:0] quarter(input int k);
    case (k)
      0:       return C_ONE;
      1:       return C_C1;
      2:       return C_C2;
      3:       return C_S1;
      default: return 64'd0;
    endcase
  endfunction

  // cos(2*pi*k/16) from the first quarter wave; -sin(x) = cos(x + pi/2)
  function automatic logic [63:0] cos16(input int k);
    int kk;
    kk = k % 16;
    if (kk > 8) kk = 16 - kk;
    if (kk > 4) return -quarter(8 - kk);
    return quarter(kk);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", 64'(in_ready), 64'(q.size() == 0 || out_ready));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("err", 64'(err), 64'(m_err));
    if (q.size() != 0) begin
      chk("out_x", out_x, q[0].x);
      chk("out_y", out_y, q[0].y);
      chk("out_l", out_l, q[0].l);
      chk("out_m", out_m, q[0].m);
      chk("out_idx", 64'(out_idx), 64'(q[0].idx));
      chk("out_last", 64'(out_last), 64'(q[0].last));
    end
  endtask

  // Called just after a rising edge; checks mid-cycle, then scores the edge.
  task automatic cycle(input bit v, input bit lst, input bit rdy,
                       input logic [63:0] re, input logic [63:0] im);
    bit   acc;
    bit   drn;
    int   e;
    exp_t s;
    in_valid  = v;
    in_last   = lst;
    out_ready = rdy;
    in_re     = re;
    in_im     = im;
    @(negedge clk);
    check_outputs();
    acc = v && (q.size() == 0 || rdy);
    drn = (q.size() != 0) && rdy;
    @(posedge clk);
    #1;
    if (drn) void'(q.pop_front());
    if (acc) begin
      e      = ((pos / 4) * (pos % 4)) % 16;
      s.x    = re;
      s.y    = im;
      s.l    = cos16(e);
      s.m    = cos16(e + 4);
      s.idx  = 4'(pos);
      s.last = (pos == 15);
      q.push_back(s);
      if (lst != (pos == 15)) m_err = 1'b1;
      pos = lst ? 0 : (pos + 1) % 16;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_x"}, out_x, 64'd0);
    chk({tag, "_y"}, out_y, 64'd0);
    chk({tag, "_l"}, out_l, 64'd0);
    chk({tag, "_m"}, out_m, 64'd0);
    chk({tag, "_idx"}, 64'(out_idx), 64'd0);
    chk({tag, "_last"}, 64'(out_last), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pos       = 0;
    m_err     = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // aligned frame, in_re=i, in_im=-i, full throughput
    for (int i = 0; i < 16; i++) cycle(1'b1, i == 15, 1'b1, 64'(i), -64'(i));
    cycle(1'b0, 1'b0, 1'b1, '0, '0);

    // random-data frame with a 3-cycle stall in the middle
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        repeat (3) cycle(1'b1, 1'b0, 1'b0, rnd64(), rnd64());
      end
      cycle(1'b1, pos == 15, 1'b1, rnd64(), rnd64());
    end

    // random valid/ready pattern, correctly framed
    for (int c = 0; c < 80; c++) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      cycle(v, v && pos == 15, $urandom_range(0, 3) != 0, rnd64(), rnd64());
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b1, '0, '0);

    // realign to a frame boundary, then an early in_last at i=9
    while (pos != 0) cycle(1'b1, pos == 15, 1'b1, rnd64(), rnd64());
    for (int i = 0; i < 10; i++) cycle(1'b1, i == 9, 1'b1, rnd64(), rnd64());
    for (int i = 0; i < 16; i++) cycle(1'b1, i == 15, 1'b1, rnd64(), rnd64());
    cycle(1'b0, 1'b0, 1'b1, '0, '0);

    // asynchronous reset while sample 7 sits in the slice
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, rnd64(), rnd64());
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("arst");
    q.delete();
    pos   = 0;
    m_err = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // frame with in_last missing at i=15, then one more sample
    for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 1'b1, rnd64(), rnd64());
    repeat (2) cycle(1'b0, 1'b0, 1'b1, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
